// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed seven-segment display driver.
// Owns a refresh prescaler and digit counter. The display value is double-buffered
// and only changes on a frame boundary. Each 4-bit code is decoded to segments.
// Also provides leading-zero blanking and one decimal point per digit.
// Optional feature macro SEG_DIM_EN: adds a 4-bit brightness input. It shortens the
// anode-on time within each scan slot.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
`ifdef SEG_DIM_EN
  input  logic [3:0]              brightness,
`endif
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [IW-1:0]           digit_idx,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // run_q gives a synchronous release. After rst_n rises, the first edge only sets run_q.
  // The scan logic starts on the second edge.
  logic                    run_q;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_dig_q, disp_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    load_ack_q, load_ack_d;
  logic                    frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    tc, last_digit, wrap;
  logic [3:0]              code_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    dim_on;
  logic [NUM_DIGITS-1:0]   an_act;
  logic [6:0]              seg_act;

  assign tc         = (presc_q == PW'(REFRESH_DIV - 1));
  assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));
  assign wrap       = run_q && tc && last_digit;

  // Unpack the committed display value into per-digit codes.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
    assign code_arr[gi] = disp_dig_q[4*gi +: 4];
  end

  // Leading-zero blanking: walk down from the top digit until the first non-zero code.
  // Digit 0 always stays lit.
  always_comb begin
    logic lead;
    blank_mask = '0;
    lead       = blank_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (code_arr[k] != 4'd0) lead = 1'b0;
      blank_mask[k] = lead;
    end
  end

`ifdef SEG_DIM_EN
  // Dim threshold. It is taken from brightness in the first cycle of each slot,
  // then held for the rest of the slot.
  logic [PW:0] thresh_q, thresh_d, thresh_now, thresh_eff;
  assign thresh_now = (PW+1)'(((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) / 32'd16);
  assign thresh_eff = (presc_q == '0) ? thresh_now : thresh_q;
  assign thresh_d   = (run_q && presc_q == '0) ? thresh_now : thresh_q;
  assign dim_on     = ({1'b0, presc_q} < thresh_eff);

  // Holds the dim threshold for the current slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thresh_q <= '0;
    else        thresh_q <= thresh_d;
  end
`else
  assign dim_on = 1'b1;
`endif

  // Active-high drive for the digit selected this cycle. It is registered below,
  // so it appears on the pins one clock later.
  assign an_act  = dim_on ? (NUM_DIGITS'(1) << idx_q) : '0;
  assign seg_act = blank_mask[idx_q] ? 7'h00 : seg_decode(code_arr[idx_q]);

  // Next state: scan counters, buffer commit and output drive.
  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    disp_dig_d    = disp_dig_q;
    disp_dp_d     = disp_dp_q;
    pend_dig_d    = pend_dig_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    load_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    an_d          = an_q;
    seg_d         = seg_q;
    dp_d          = dp_q;
    if (run_q) begin
      if (tc) begin
        presc_d = '0;
        idx_d   = last_digit ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      frame_start_d = wrap;
      // A load that lands on the wrap edge bypasses the pending buffer.
      if (wrap && load) begin
        disp_dig_d   = digits_in;
        disp_dp_d    = dp_in;
        pend_valid_d = 1'b0;
        load_ack_d   = 1'b1;
      end else if (wrap && pend_valid_q) begin
        disp_dig_d   = pend_dig_q;
        disp_dp_d    = pend_dp_q;
        pend_valid_d = 1'b0;
        load_ack_d   = 1'b1;
      end else if (load) begin
        pend_dig_d   = digits_in;
        pend_dp_d    = dp_in;
        pend_valid_d = 1'b1;
      end
      an_d  = ACTIVE_LOW ? ~an_act : an_act;
      seg_d = ACTIVE_LOW ? ~seg_act : seg_act;
      dp_d  = ACTIVE_LOW ? ~disp_dp_q[idx_q] : disp_dp_q[idx_q];
    end
  end

  // Release qualifier: rises on the first edge after rst_n is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // State registers. While in reset, the pins are held at their inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      disp_dig_q    <= '0;
      disp_dp_q     <= '0;
      pend_dig_q    <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= {NUM_DIGITS{ACTIVE_LOW}};
      seg_q         <= {7{ACTIVE_LOW}};
      dp_q          <= ACTIVE_LOW;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      disp_dig_q    <= disp_dig_d;
      disp_dp_q     <= disp_dp_d;
      pend_dig_q    <= pend_dig_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;
  assign digit_idx   = idx_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (4 digits, 4-cycle slots, active-low pins).
// When SEG_DIM_EN is defined, a second 16-cycle instance checks the dimming.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        load_ack, frame_start, dp;
  logic [1:0]  digit_idx;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz),
`ifdef SEG_DIM_EN
    .brightness(4'd15),
`endif
    .load_ack(load_ack), .frame_start(frame_start), .digit_idx(digit_idx),
    .an(an), .seg(seg), .dp(dp)
  );

`ifdef SEG_DIM_EN
  logic       ack_dim, fs_dim, dp_dim;
  logic [1:0] idx_dim;
  logic [3:0] an_dim;
  logic [6:0] seg_dim;
  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(16), .ACTIVE_LOW(1'b1)) u_dim (
    .clk(clk), .rst_n(rst_n), .digits_in(16'h0000), .dp_in(4'b0000), .load(1'b0),
    .blank_lz(1'b0), .brightness(4'd7),
    .load_ack(ack_dim), .frame_start(fs_dim), .digit_idx(idx_dim),
    .an(an_dim), .seg(seg_dim), .dp(dp_dim)
  );
`endif

  // Hand-entered active-high patterns (a = bit 0).
  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge that sees frame_start, bounded.
  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    if (frame_start !== 1'b1) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    $display("load digits=%h dp=%b", v, d);
    digits_in = v;
    dp_in     = d;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // Starts at frame cycle 0 and ends at cycle 14. Digit k is on the pins in cycles 4k+1..4k+4.
  task automatic read_frame(input bit exp_ack, input bit do_wait, input logic [15:0] codes,
                            input logic [3:0] bmask, input logic [3:0] dmask);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    if (do_wait) wait_fs();
    chk("frame_start", frame_start, 1'b1);
    chk("load_ack", load_ack, exp_ack);
    step(1);
    chk("ack_pulse", load_ack, 1'b0);
    chk("fs_pulse", frame_start, 1'b0);
    $display("frame expect digits=%h blank=%b dp=%b", codes, bmask, dmask);
    for (int k = 0; k < 4; k++) begin
      step((k == 0) ? 1 : 4);
      ea = ~(4'b0001 << k);
      es = bmask[k] ? 7'h7F : ~seg_of(codes[4*k +: 4]);
      ed = ~dmask[k];
      chk($sformatf("an_d%0d", k), an, ea);
      chk($sformatf("seg_d%0d", k), seg, es);
      chk($sformatf("dp_d%0d", k), dp, ed);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         exp_idx;
    logic [3:0] ea;
    // Reset: all pins are held inactive.
    step(3);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1'b1);
    chk("rst_idx", digit_idx, 2'd0);
    chk("rst_ack", load_ack, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;
    // Scan order. c counts negedges after release, and the first posedge only syncs the release.
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp_idx = ((c - 1) / 4) % 4;
      chk("scan_idx", digit_idx, exp_idx);
      chk("scan_fs", frame_start, (c > 1 && (c - 1) % 16 == 0));
      if (c == 1) begin
        chk("scan_an0", an, 4'hF);
      end else begin
        ea = ~(4'b0001 << (((c - 2) / 4) % 4));
        chk("scan_an", an, ea);
        chk("scan_seg", seg, 7'h40);
      end
    end

    // Commit timing: a mid-frame load waits for the wrap.
    wait_fs();
    step(5);
    do_load(16'h1234, 4'b0000);
    step(4);
    chk("precommit_an", an, 4'b1011);
    chk("precommit_seg", seg, 7'h40);
    read_frame(1'b1, 1'b1, 16'h1234, 4'b0000, 4'b0000);

    // Overwrite: the last load before the wrap wins, with one ack.
    wait_fs();
    chk("no_extra_ack", load_ack, 1'b0);
    step(3);
    do_load(16'h1111, 4'b0000);
    step(2);
    do_load(16'h2222, 4'b0000);
    read_frame(1'b1, 1'b1, 16'h2222, 4'b0000, 4'b0000);

    // Coincident load: it is sampled on the wrap edge and committed directly.
    wait_fs();
    chk("ow_single_ack", load_ack, 1'b0);
    step(15);
    do_load(16'h5678, 4'b0000);
    read_frame(1'b1, 1'b0, 16'h5678, 4'b0000, 4'b0000);
    read_frame(1'b0, 1'b1, 16'h5678, 4'b0000, 4'b0000);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    wait_fs(); step(5); do_load(16'h0050, 4'b0000);
    read_frame(1'b1, 1'b1, 16'h0050, 4'b1100, 4'b0000);
    wait_fs(); step(5); do_load(16'h0000, 4'b0000);
    read_frame(1'b1, 1'b1, 16'h0000, 4'b1110, 4'b0000);
    blank_lz = 1'b0;
    read_frame(1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000);
    wait_fs(); step(5); do_load(16'h0050, 4'b0000);
    read_frame(1'b1, 1'b1, 16'h0050, 4'b0000, 4'b0000);

    // Hex decode and decimal point.
    wait_fs(); step(5); do_load(16'hABCD, 4'b0100);
    read_frame(1'b1, 1'b1, 16'hABCD, 4'b0000, 4'b0100);

    // Async reset while digit 2 is driven, with a load still pending.
    wait_fs(); step(5); do_load(16'h9999, 4'b1111);
    step(3);
    chk("pre_rst_idx", digit_idx, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dp", dp, 1'b1);
    chk("arst_idx", digit_idx, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_frame(1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000);

`ifdef SEG_DIM_EN
    begin
      int n = 0;
      int cnt = 0;
      do begin
        @(negedge clk);
        n++;
      end while (fs_dim !== 1'b1 && n < 200);
      if (fs_dim !== 1'b1) chk("dim_fs_timeout", 32'd0, 32'd1);
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk);
        if (an_dim[0] == 1'b0) cnt++;
        if (c == 1) chk("dim_first_on", an_dim, 4'b1110);
        if (c == 9) chk("dim_off", an_dim, 4'b1111);
      end
      chk("dim_on_cycles", cnt, 8);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
